// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller: mcause codes and FSM states.
// Optional interrupt path is enabled with the TRAP_IRQ_EN macro.
package trap_pkg;

  localparam logic [31:0] CAUSE_INST_MISALIGNED = 32'd0;
  localparam logic [31:0] CAUSE_ILLEGAL         = 32'd2;
  localparam logic [31:0] CAUSE_BREAKPOINT      = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M         = 32'd11;
  localparam logic [31:0] CAUSE_M_EXT_IRQ       = 32'h8000_000B;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_COMMIT   = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_MRET     = 3'd4
  } trap_state_e;

endpackage

// File: rtl/trap_controller_if.sv
// Execute-stage / CSR-file / fetch-mux signal bundle of the trap controller.
// irq_ext and irq_mie exist only when TRAP_IRQ_EN is defined.
interface trap_controller_if #(
  parameter int unsigned XLEN = 32
);
`ifdef TRAP_IRQ_EN
  logic            irq_ext;
  logic            irq_mie;
`endif
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic            ex_misaligned_fetch;
  logic            ex_illegal;
  logic            ex_is_ebreak;
  logic            ex_is_ecall;
  logic            ex_is_mret;
  logic            ex_ready;
  logic            exception_en;
  logic [XLEN-1:0] exception_pc;
  logic [XLEN-1:0] exception_cause;
  logic            mret_en;
  logic [XLEN-1:0] mtvec_in;
  logic [XLEN-1:0] mepc_in;
  logic            pipe_flush;
  logic            pipe_stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
`ifdef TRAP_IRQ_EN
    output irq_ext, irq_mie,
`endif
    output ex_valid, ex_pc, ex_misaligned_fetch, ex_illegal, ex_is_ebreak,
           ex_is_ecall, ex_is_mret, mtvec_in, mepc_in,
    input  ex_ready, exception_en, exception_pc, exception_cause, mret_en,
           pipe_flush, pipe_stall, redirect_valid, redirect_pc
  );

  modport slave (
`ifdef TRAP_IRQ_EN
    input  irq_ext, irq_mie,
`endif
    input  ex_valid, ex_pc, ex_misaligned_fetch, ex_illegal, ex_is_ebreak,
           ex_is_ecall, ex_is_mret, mtvec_in, mepc_in,
    output ex_ready, exception_en, exception_pc, exception_cause, mret_en,
           pipe_flush, pipe_stall, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/trap_cause_encoder.sv
// Priority encoder from execute-stage flags to {take, cause, is_mret}.
// With TRAP_IRQ_EN, a pending enabled interrupt ranks below every synchronous exception.
module trap_cause_encoder
  import trap_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
`ifdef TRAP_IRQ_EN
  input  logic            irq_ext,
  input  logic            irq_mie,
`endif
  input  logic            valid,
  input  logic            misaligned_fetch,
  input  logic            illegal,
  input  logic            is_ebreak,
  input  logic            is_ecall,
  input  logic            is_mret_in,
  output logic            take,
  output logic [XLEN-1:0] cause,
  output logic            is_mret
);

  always_comb begin
    take    = 1'b0;
    cause   = '0;
    is_mret = 1'b0;
    if (valid) begin
      if (misaligned_fetch) begin
        take  = 1'b1;
        cause = XLEN'(CAUSE_INST_MISALIGNED);
      end else if (illegal) begin
        take  = 1'b1;
        cause = XLEN'(CAUSE_ILLEGAL);
      end else if (is_ebreak) begin
        take  = 1'b1;
        cause = XLEN'(CAUSE_BREAKPOINT);
      end else if (is_ecall) begin
        take  = 1'b1;
        cause = XLEN'(CAUSE_ECALL_M);
`ifdef TRAP_IRQ_EN
      end else if (irq_ext && irq_mie) begin
        take  = 1'b1;
        cause = XLEN'(CAUSE_M_EXT_IRQ);
`endif
      end else if (is_mret_in) begin
        is_mret = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap initiator: turns exception/MRET requests into CSR strobes, flush/stall and PC redirect.
// Define TRAP_IRQ_EN to add the external-interrupt trap path.
module trap_controller
  import trap_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input logic               clk,
  input logic               rst,
  trap_controller_if.slave  bus
);

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  trap_state_e     state_q;
  logic [2:0]      cnt_q;
  logic [XLEN-1:0] pc_hold_q, cause_hold_q, exc_pc_q, exc_cause_q;
  logic            ready_q, flush_q, stall_q, exc_en_q, mret_q, redir_q;
  logic            take, is_mret, idle_ok, accept_trap, accept_mret;
  logic [XLEN-1:0] cause, redir_src;

  trap_cause_encoder #(.XLEN(XLEN)) u_enc (
`ifdef TRAP_IRQ_EN
    .irq_ext          (bus.irq_ext),
    .irq_mie          (bus.irq_mie),
`endif
    .valid            (bus.ex_valid),
    .misaligned_fetch (bus.ex_misaligned_fetch),
    .illegal          (bus.ex_illegal),
    .is_ebreak        (bus.ex_is_ebreak),
    .is_ecall         (bus.ex_is_ecall),
    .is_mret_in       (bus.ex_is_mret),
    .take             (take),
    .cause            (cause),
    .is_mret          (is_mret)
  );

  assign idle_ok     = (state_q == ST_IDLE) && !rst;
  assign accept_trap = idle_ok && take;
  assign accept_mret = idle_ok && is_mret;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pc_hold_q    <= '0;
      cause_hold_q <= '0;
      exc_pc_q     <= '0;
      exc_cause_q  <= '0;
      ready_q      <= 1'b1;
      flush_q      <= 1'b0;
      stall_q      <= 1'b0;
      exc_en_q     <= 1'b0;
      mret_q       <= 1'b0;
      redir_q      <= 1'b0;
    end else begin
      // Output registers are loaded on entry to the state that owns them.
      unique case (state_q)
        ST_IDLE: begin
          if (accept_trap) begin
            state_q      <= ST_FLUSH;
            pc_hold_q    <= bus.ex_pc;
            cause_hold_q <= cause;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            flush_q      <= 1'b1;
            stall_q      <= 1'b1;
          end else if (accept_mret) begin
            state_q <= ST_MRET;
            ready_q <= 1'b0;
            mret_q  <= 1'b1;
            redir_q <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (cnt_q == FLUSH_LAST) begin
            state_q     <= ST_COMMIT;
            flush_q     <= 1'b0;
            exc_en_q    <= 1'b1;
            exc_pc_q    <= pc_hold_q;
            exc_cause_q <= cause_hold_q;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        ST_COMMIT: begin
          state_q  <= ST_REDIRECT;
          exc_en_q <= 1'b0;
          stall_q  <= 1'b0;
          redir_q  <= 1'b1;
        end
        ST_REDIRECT: begin
          state_q <= ST_IDLE;
          redir_q <= 1'b0;
          ready_q <= 1'b1;
        end
        ST_MRET: begin
          state_q <= ST_IDLE;
          mret_q  <= 1'b0;
          redir_q <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Target is taken live from the CSR file so a same-cycle mtvec/mepc write is honoured.
  always_comb begin
    redir_src       = (state_q == ST_MRET) ? bus.mepc_in : bus.mtvec_in;
    bus.redirect_pc = '0;
    if (redir_q && !rst) bus.redirect_pc = {redir_src[XLEN-1:2], 2'b00};
  end

  assign bus.ex_ready        = ready_q;
  assign bus.exception_en    = exc_en_q && !rst;
  assign bus.mret_en         = mret_q && !rst;
  assign bus.redirect_valid  = redir_q && !rst;
  assign bus.pipe_stall      = stall_q && !rst;
  assign bus.pipe_flush      = (flush_q || accept_trap || accept_mret) && !rst;
  assign bus.exception_pc    = exc_pc_q;
  assign bus.exception_cause = exc_cause_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed self-checking bench for trap_controller (FLUSH_CYCLES=1); IRQ steps run when TRAP_IRQ_EN is defined.
module tb_trap_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  trap_controller_if #(.XLEN(32)) bus ();

  trap_controller #(.XLEN(32), .FLUSH_CYCLES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // f = {misaligned, illegal, ebreak, ecall}
  task automatic drive(input logic v, input logic [3:0] f, input logic m, input logic [31:0] pc);
    bus.ex_valid            = v;
    bus.ex_misaligned_fetch = f[3];
    bus.ex_illegal          = f[2];
    bus.ex_is_ebreak        = f[1];
    bus.ex_is_ecall         = f[0];
    bus.ex_is_mret          = m;
    bus.ex_pc               = pc;
  endtask

  // Full trap from IDLE; mtvec holds a decoy until the redirect cycle.
  task automatic trap_seq(input string tag, input logic [3:0] f, input logic [31:0] pc,
                          input logic [31:0] vec, input logic [31:0] exp_cause,
                          input logic [31:0] exp_target);
    bus.mtvec_in = 32'h0000_FFF0;
    drive(1'b1, f, 1'b0, pc);
    smp();
    chk({tag, "/c0_flush"}, bus.pipe_flush, 1);
    chk({tag, "/c0_ready"}, bus.ex_ready, 1);
    next();
    drive(1'b0, 4'b0000, 1'b0, 32'h0);
    smp();
    chk({tag, "/c1_flush"}, bus.pipe_flush, 1);
    chk({tag, "/c1_stall"}, bus.pipe_stall, 1);
    chk({tag, "/c1_ready"}, bus.ex_ready, 0);
    chk({tag, "/c1_en"}, bus.exception_en, 0);
    next();
    smp();
    chk({tag, "/c2_en"}, bus.exception_en, 1);
    chk({tag, "/c2_pc"}, bus.exception_pc, pc);
    chk({tag, "/c2_cause"}, bus.exception_cause, exp_cause);
    chk({tag, "/c2_stall"}, bus.pipe_stall, 1);
    chk({tag, "/c2_flush"}, bus.pipe_flush, 0);
    chk({tag, "/c2_redir"}, bus.redirect_valid, 0);
    next();
    bus.mtvec_in = vec;
    smp();
    chk({tag, "/c3_redir"}, bus.redirect_valid, 1);
    chk({tag, "/c3_target"}, bus.redirect_pc, exp_target);
    chk({tag, "/c3_en"}, bus.exception_en, 0);
    chk({tag, "/c3_stall"}, bus.pipe_stall, 0);
    chk({tag, "/c3_mret"}, bus.mret_en, 0);
    next();
    smp();
    chk({tag, "/c4_ready"}, bus.ex_ready, 1);
    chk({tag, "/c4_redir"}, bus.redirect_valid, 0);
    chk({tag, "/c4_pc_hold"}, bus.exception_pc, pc);
    chk({tag, "/c4_en"}, bus.exception_en, 0);
    next();
  endtask

  initial begin
    drive(1'b0, 4'b0000, 1'b0, 32'h0);
    bus.mtvec_in = 32'h0;
    bus.mepc_in  = 32'h0;
`ifdef TRAP_IRQ_EN
    bus.irq_ext = 1'b0;
    bus.irq_mie = 1'b0;
`endif
    next();
    next();
    smp();
    chk("rst_held/en", bus.exception_en, 0);
    chk("rst_held/flush", bus.pipe_flush, 0);
    next();
    rst = 1'b0;
    smp();
    chk("reset/ready", bus.ex_ready, 1);
    chk("reset/en", bus.exception_en, 0);
    chk("reset/mret", bus.mret_en, 0);
    chk("reset/flush", bus.pipe_flush, 0);
    chk("reset/stall", bus.pipe_stall, 0);
    chk("reset/redir", bus.redirect_valid, 0);
    chk("reset/rpc", bus.redirect_pc, 0);
    chk("reset/epc", bus.exception_pc, 0);
    chk("reset/cause", bus.exception_cause, 0);
    next();

    // Valid with no flag, and flags without valid: nothing happens.
    drive(1'b1, 4'b0000, 1'b0, 32'h50);
    smp();
    chk("noflag/flush", bus.pipe_flush, 0);
    next();
    drive(1'b0, 4'b0101, 1'b1, 32'h54);
    smp();
    chk("novalid/flush", bus.pipe_flush, 0);
    chk("novalid/ready", bus.ex_ready, 1);
    next();
    drive(1'b0, 4'b0000, 1'b0, 32'h0);
    smp();
    chk("idle/ready", bus.ex_ready, 1);
    chk("idle/en", bus.exception_en, 0);
    next();

    trap_seq("ecall",     4'b0001, 32'h100, 32'h800, 32'd11, 32'h800);
    trap_seq("ill_ecall", 4'b0101, 32'h204, 32'h800, 32'd2,  32'h800);
    trap_seq("ebreak",    4'b0011, 32'h208, 32'h840, 32'd3,  32'h840);
    trap_seq("mis_all",   4'b1111, 32'h20A, 32'h844, 32'd0,  32'h844);
    trap_seq("mtvec_mode", 4'b0001, 32'h600, 32'h803, 32'd11, 32'h800);

    // MRET
    bus.mtvec_in = 32'h900;
    bus.mepc_in  = 32'h104;
    drive(1'b1, 4'b0000, 1'b1, 32'h700);
    smp();
    chk("mret/c0_flush", bus.pipe_flush, 1);
    chk("mret/c0_mret", bus.mret_en, 0);
    next();
    drive(1'b0, 4'b0000, 1'b0, 32'h0);
    smp();
    chk("mret/c1_mret", bus.mret_en, 1);
    chk("mret/c1_redir", bus.redirect_valid, 1);
    chk("mret/c1_target", bus.redirect_pc, 32'h104);
    chk("mret/c1_en", bus.exception_en, 0);
    chk("mret/c1_ready", bus.ex_ready, 0);
    next();
    smp();
    chk("mret/c2_mret", bus.mret_en, 0);
    chk("mret/c2_ready", bus.ex_ready, 1);
    chk("mret/c2_redir", bus.redirect_valid, 0);
    next();

    // Second ecall held while busy; accepted only on return to IDLE.
    bus.mtvec_in = 32'h800;
    drive(1'b1, 4'b0001, 1'b0, 32'h300);
    smp();
    chk("busy/c0_flush", bus.pipe_flush, 1);
    next();
    drive(1'b1, 4'b0001, 1'b0, 32'h400);
    smp();
    chk("busy/c1_ready", bus.ex_ready, 0);
    next();
    smp();
    chk("busy/c2_pc", bus.exception_pc, 32'h300);
    chk("busy/c2_en", bus.exception_en, 1);
    next();
    smp();
    chk("busy/c3_redir", bus.redirect_valid, 1);
    next();
    smp();
    chk("busy/c4_ready", bus.ex_ready, 1);
    chk("busy/c4_reaccept", bus.pipe_flush, 1);
    next();
    drive(1'b0, 4'b0000, 1'b0, 32'h0);
    smp();
    chk("busy/r1_redir", bus.redirect_valid, 0);
    next();
    smp();
    chk("busy/r2_redir", bus.redirect_valid, 0);
    chk("busy/r2_pc", bus.exception_pc, 32'h400);
    chk("busy/r2_en", bus.exception_en, 1);
    next();
    smp();
    chk("busy/r3_redir", bus.redirect_valid, 1);
    chk("busy/r3_target", bus.redirect_pc, 32'h800);
    next();
    smp();
    chk("busy/r4_ready", bus.ex_ready, 1);
    next();

    // Reset while in COMMIT.
    drive(1'b1, 4'b0001, 1'b0, 32'h500);
    next();
    drive(1'b0, 4'b0000, 1'b0, 32'h0);
    next();
    rst = 1'b1;
    smp();
    chk("rstc/en_suppressed", bus.exception_en, 0);
    chk("rstc/stall", bus.pipe_stall, 0);
    next();
    rst = 1'b0;
    smp();
    chk("rstc/ready", bus.ex_ready, 1);
    chk("rstc/en", bus.exception_en, 0);
    chk("rstc/flush", bus.pipe_flush, 0);
    chk("rstc/stall2", bus.pipe_stall, 0);
    chk("rstc/redir", bus.redirect_valid, 0);
    chk("rstc/epc", bus.exception_pc, 0);
    chk("rstc/cause", bus.exception_cause, 0);
    next();
    smp();
    chk("rstc/en_after", bus.exception_en, 0);
    chk("rstc/redir_after", bus.redirect_valid, 0);
    next();

`ifdef TRAP_IRQ_EN
    bus.irq_ext = 1'b1;
    bus.irq_mie = 1'b1;
    smp();
    chk("irq/novalid_flush", bus.pipe_flush, 0);
    next();
    trap_seq("irq",      4'b0000, 32'h300, 32'h803, 32'h8000_000B, 32'h800);
    bus.irq_ext = 1'b1;
    bus.irq_mie = 1'b1;
    trap_seq("irq_sync", 4'b0100, 32'h304, 32'h800, 32'd2, 32'h800);
    bus.irq_mie = 1'b0;
    drive(1'b1, 4'b0000, 1'b0, 32'h308);
    smp();
    chk("irq/masked_flush", bus.pipe_flush, 0);
    next();
    drive(1'b0, 4'b0000, 1'b0, 32'h0);
    bus.irq_ext = 1'b0;
    next();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no end expected end");
    $fatal(1, "timeout");
  end

endmodule
